quadrilatero_register_lsu_engine: RTL and testbench

Execution end of the matrix load/store path. Accepts one issued LSU instruction per start pulse from the issue controller. Walks the configured rows of one matrix register, issuing one OBI-style memory beat per row. Loads write rows into the register file; stores read rows from it. Holds busy_o high until every response has returned.

---
 rtl/quadrilatero_register_lsu_engine.sv | 162 ++++++++++++++++
 tb/tb_quadrilatero_register_lsu_engine.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrilatero_register_lsu_engine.sv
// Matrix-register LSU engine: walks the rows of one register, one memory beat per row.
// Optional alignment rejection is enabled with QUADRILATERO_LSU_MISALIGN_CHECK_EN.
module quadrilatero_register_lsu_engine #(
    parameter int N_ROWS          = 4,
    parameter int N_REGS          = 8,
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      instr_is_store_i,
    input  logic [$clog2(N_REGS)-1:0] instr_reg_i,
    input  logic [ADDR_W-1:0]         instr_addr_i,
    input  logic [ADDR_W-1:0]         instr_stride_i,
    input  logic [$clog2(N_ROWS):0]   conf_rows_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    output logic                      rf_we_o,
    output logic [$clog2(N_REGS)-1:0] rf_wreg_o,
    output logic [$clog2(N_ROWS)-1:0] rf_wrow_o,
    output logic [DATA_W-1:0]         rf_wdata_o,
    output logic [$clog2(N_REGS)-1:0] rf_rreg_o,
    output logic [$clog2(N_ROWS)-1:0] rf_rrow_o,
    input  logic [DATA_W-1:0]         rf_rdata_i
);
    localparam int RW   = $clog2(N_ROWS) + 1;
    localparam int ROWW = $clog2(N_ROWS);
    localparam int RGW  = $clog2(N_REGS);
    localparam int OW   = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              busy_q, busy_d;
    logic              store_q, store_d;
    logic [RGW-1:0]    reg_q, reg_d;
    logic [RW-1:0]     rows_q, rows_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [RW-1:0]     req_cnt_q, req_cnt_d;
    logic [RW-1:0]     resp_cnt_q, resp_cnt_d;
    logic [OW-1:0]     out_q, out_d;

    logic          req_ok, gnt, rsp, done, misaligned;
    logic [RW-1:0] rows_sat;

`ifdef QUADRILATERO_LSU_MISALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(DATA_W / 8 - 1);
    logic err_q, err_d;

    assign misaligned = (|(instr_addr_i & ALIGN_MASK)) || (|(instr_stride_i & ALIGN_MASK));

    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && start_i) err_d = misaligned;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign error_o = done & err_q;
`else
    assign misaligned = 1'b0;
    assign error_o    = 1'b0;
`endif

    assign rows_sat = (conf_rows_i > RW'(N_ROWS)) ? RW'(N_ROWS) : conf_rows_i;
    assign req_ok   = (state_q == S_ISSUE) && (req_cnt_q < rows_q) && (out_q < OW'(MAX_OUTSTANDING));
    assign gnt      = req_ok && mem_gnt_i;
    // Responses with nothing in flight (idle, or after a reset) are dropped.
    assign rsp      = mem_rvalid_i && (state_q != S_IDLE) && (out_q != '0);
    assign done     = (state_q == S_DRAIN) && (resp_cnt_q == rows_q);

    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        reg_d      = reg_q;
        rows_d     = rows_q;
        addr_d     = addr_q;
        stride_d   = stride_q;
        req_cnt_d  = req_cnt_q;
        resp_cnt_d = resp_cnt_q;
        out_d      = out_q + OW'(gnt) - OW'(rsp);
        if (gnt) begin
            req_cnt_d = req_cnt_q + RW'(1);
            addr_d    = addr_q + stride_q;
        end
        if (rsp) resp_cnt_d = resp_cnt_q + RW'(1);
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    store_d    = instr_is_store_i;
                    reg_d      = instr_reg_i;
                    addr_d     = instr_addr_i;
                    stride_d   = instr_stride_i;
                    rows_d     = misaligned ? '0 : rows_sat;
                    req_cnt_d  = '0;
                    resp_cnt_d = '0;
                    out_d      = '0;
                    state_d    = (rows_d == '0) ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: if (req_cnt_d == rows_q) state_d = S_DRAIN;
            S_DRAIN: if (done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            store_q    <= 1'b0;
            reg_q      <= '0;
            rows_q     <= '0;
            addr_q     <= '0;
            stride_q   <= '0;
            req_cnt_q  <= '0;
            resp_cnt_q <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            store_q    <= store_d;
            reg_q      <= reg_d;
            rows_q     <= rows_d;
            addr_q     <= addr_d;
            stride_q   <= stride_d;
            req_cnt_q  <= req_cnt_d;
            resp_cnt_q <= resp_cnt_d;
            out_q      <= out_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done;
    assign mem_req_o   = req_ok;
    assign mem_we_o    = req_ok & store_q;
    assign mem_addr_o  = req_ok ? addr_q : '0;
    assign mem_wdata_o = (req_ok && store_q) ? rf_rdata_i : '0;
    assign rf_rreg_o   = reg_q;
    assign rf_rrow_o   = req_cnt_q[ROWW-1:0];
    assign rf_we_o     = rsp & ~store_q;
    assign rf_wreg_o   = reg_q;
    assign rf_wrow_o   = resp_cnt_q[ROWW-1:0];
    assign rf_wdata_o  = rf_we_o ? mem_rdata_i : '0;
endmodule

// File: tb/tb_quadrilatero_register_lsu_engine.sv
// Scoreboard bench for the matrix LSU engine: a reference model queues expected beats,
// register-file writes and completions; a monitor pops and compares each cycle.
module tb_quadrilatero_register_lsu_engine;
    localparam int MAXO = 2;

    logic        clk = 0, rst_i = 1, start_i = 0, instr_is_store_i = 0;
    logic [2:0]  instr_reg_i = '0, conf_rows_i = '0;
    logic [31:0] instr_addr_i = '0, instr_stride_i = '0;
    logic        busy_o, done_o, error_o, mem_req_o, mem_we_o, rf_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, rf_wdata_o, rf_rdata_i;
    logic        mem_gnt_i = 0, mem_rvalid_i = 0;
    logic [31:0] mem_rdata_i = '0;
    logic [2:0]  rf_wreg_o, rf_rreg_o;
    logic [1:0]  rf_wrow_o, rf_rrow_o;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } req_t;
    typedef struct { logic [2:0] rg; logic [1:0] row; logic [31:0] data; } rfw_t;
    typedef struct { logic err; logic zero; } done_t;
    typedef struct { logic [31:0] data; int due; } pend_t;

    req_t  exp_req[$];
    rfw_t  exp_rfw[$];
    done_t exp_done[$];
    pend_t pend[$];
    int checks = 0, errors = 0, cyc = 0;
    int gnt_mode = 0, stall_left = 0, lat_min = 1, lat_max = 1;
    bit spur_en = 0;

    quadrilatero_register_lsu_engine dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .instr_is_store_i(instr_is_store_i),
        .instr_reg_i(instr_reg_i), .instr_addr_i(instr_addr_i), .instr_stride_i(instr_stride_i),
        .conf_rows_i(conf_rows_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .rf_we_o(rf_we_o), .rf_wreg_o(rf_wreg_o),
        .rf_wrow_o(rf_wrow_o), .rf_wdata_o(rf_wdata_o), .rf_rreg_o(rf_rreg_o),
        .rf_rrow_o(rf_rrow_o), .rf_rdata_i(rf_rdata_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rf_val(input logic [2:0] r, input logic [1:0] w);
        return {8'hC0, 5'd0, r, 14'd0, w};
    endfunction
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign rf_rdata_i = rf_val(rf_rreg_o, rf_rrow_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory slave: grant policy plus in-order responses after a chosen latency.
    always @(negedge clk) begin
        case (gnt_mode)
            0: mem_gnt_i = 1'b1;
            1: mem_gnt_i = 1'($urandom_range(1, 0));
            default: begin
                if (mem_req_o && stall_left > 0) begin
                    mem_gnt_i = 1'b0;
                    stall_left--;
                end else mem_gnt_i = 1'b1;
            end
        endcase
        if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = pend[0].data;
            void'(pend.pop_front());
        end else begin
            mem_rvalid_i = spur_en && pend.size() == 0 && $urandom_range(7, 0) == 0;
            mem_rdata_i  = $urandom;
        end
        #1;
        if (!rst_i && mem_req_o && mem_gnt_i)
            pend.push_back('{mem_val(mem_addr_o), cyc + 1 + int'($urandom_range(lat_max, lat_min))});
    end

    // Monitor
    logic        req_prev = 0, gnt_prev = 0, start_prev = 0, done_prev = 0, cur_store = 0;
    logic [31:0] addr_prev = '0, wdata_prev = '0;
    int          outs = 0, outs0, busy_len = 0;
    logic        exp_we;
    req_t        er;
    rfw_t        ew;
    done_t       ed;

    always @(negedge clk) begin
        #2;
        if (rst_i) begin
            exp_req.delete(); exp_rfw.delete(); exp_done.delete();
            outs = 0; req_prev = 0; start_prev = 0; done_prev = 0; busy_len = 0;
        end else begin
            outs0 = outs;
            if (start_prev) chk("busy_after_start", 32'(busy_o), 32'd1);
            if (done_prev)  chk("busy_after_done", 32'(busy_o), 32'd0);
            exp_we = mem_rvalid_i && outs0 > 0 && !cur_store;
            chk("rf_we", 32'(rf_we_o), 32'(exp_we));
            if (mem_rvalid_i && outs0 > 0) outs--;
            if (rf_we_o && exp_we) begin
                if (exp_rfw.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rf_write: unexpected write row %0d", rf_wrow_o);
                end else begin
                    ew = exp_rfw.pop_front();
                    chk("rf_wreg", 32'(rf_wreg_o), 32'(ew.rg));
                    chk("rf_wrow", 32'(rf_wrow_o), 32'(ew.row));
                    chk("rf_wdata", rf_wdata_o, ew.data);
                end
            end
            if (mem_req_o) chk("outstanding_limit", 32'(outs0 < MAXO), 32'd1);
            if (req_prev && !gnt_prev) begin
                chk("req_held", 32'(mem_req_o), 32'd1);
                chk("addr_stable", mem_addr_o, addr_prev);
                chk("wdata_stable", mem_wdata_o, wdata_prev);
            end
            if (mem_req_o && mem_gnt_i) begin
                outs++;
                if (exp_req.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_req: unexpected beat addr %0h", mem_addr_o);
                end else begin
                    er = exp_req.pop_front();
                    chk("mem_addr", mem_addr_o, er.addr);
                    chk("mem_we", 32'(mem_we_o), 32'(er.we));
                    if (er.we) chk("mem_wdata", mem_wdata_o, er.wdata);
                end
            end
            if (busy_o) busy_len++; else busy_len = 0;
            if (done_o) begin
                if (exp_done.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done: unexpected done pulse");
                end else begin
                    ed = exp_done.pop_front();
                    chk("error_flag", 32'(error_o), 32'(ed.err));
                    chk("beats_left", 32'(exp_req.size()), 32'd0);
                    chk("rf_writes_left", 32'(exp_rfw.size()), 32'd0);
                    if (ed.zero) chk("busy_len_zero_rows", 32'(busy_len), 32'd1);
                end
            end else if (error_o) chk("error_without_done", 32'(error_o), 32'd0);
            req_prev   = mem_req_o;
            gnt_prev   = mem_gnt_i;
            addr_prev  = mem_addr_o;
            wdata_prev = mem_wdata_o;
            done_prev  = done_o;
            start_prev = start_i && !busy_o;
            if (start_i && !busy_o) cur_store = instr_is_store_i;
        end
    end

    // Reference model: expected beats from base + k*stride, saturated row count.
    task automatic issue(input bit st, input logic [2:0] rg, input logic [31:0] a,
                         input logic [31:0] s, input logic [2:0] rows);
        int n;
        bit mis;
        logic [31:0] ak;
        @(negedge clk);
        start_i = 1; instr_is_store_i = st; instr_reg_i = rg;
        instr_addr_i = a; instr_stride_i = s; conf_rows_i = rows;
        n = (int'(rows) > 4) ? 4 : int'(rows);
        mis = 0;
`ifdef QUADRILATERO_LSU_MISALIGN_CHECK_EN
        mis = (a % 32'd4 != 0) || (s % 32'd4 != 0);
`endif
        if (mis) n = 0;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k) * s;
            exp_req.push_back('{ak, st, st ? rf_val(rg, 2'(k)) : 32'd0});
            if (!st) exp_rfw.push_back('{rg, 2'(k), mem_val(ak)});
        end
        exp_done.push_back('{mis, n == 0});
        @(negedge clk);
        start_i = 0;
    endtask

    task automatic bogus_start();
        start_i = 1; instr_is_store_i = 1'($urandom); instr_reg_i = 3'($urandom);
        instr_addr_i = $urandom & ~32'h3; instr_stride_i = 32'h40; conf_rows_i = 3'd4;
        @(negedge clk);
        start_i = 0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy_o || exp_done.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) begin
            checks++; errors++;
            $display("FAIL timeout: still busy after %0d cycles", n);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_req", 32'(mem_req_o), 32'd0);
        chk("reset_rf_we", 32'(rf_we_o), 32'd0);
        chk("reset_error", 32'(error_o), 32'd0);
        rst_i = 0;
        repeat (2) @(negedge clk);

        // Load 4 rows, always granted, one-cycle response latency.
        gnt_mode = 0; lat_min = 1; lat_max = 1;
        issue(0, 3'd2, 32'h1000, 32'h10, 3'd4);
        wait_idle(200);

        // Store 3 rows with a 5-cycle stall on the first beat.
        gnt_mode = 2; stall_left = 5; lat_min = 1; lat_max = 3;
        issue(1, 3'd5, 32'h2000, 32'h20, 3'd3);
        wait_idle(200);

        // Long response latency exercises the outstanding limit; a start while busy is ignored.
        gnt_mode = 0; lat_min = 6; lat_max = 6;
        issue(0, 3'd1, 32'h3000, 32'h8, 3'd4);
        bogus_start();
        wait_idle(200);

        // Zero rows, with an ignored start during its single busy cycle.
        lat_min = 1; lat_max = 1;
        issue(0, 3'd3, 32'h4000, 32'h4, 3'd0);
        bogus_start();
        wait_idle(50);

        // Address wrap-around.
        issue(0, 3'd6, 32'hFFFF_FFF0, 32'h10, 3'd2);
        wait_idle(100);

        // Misaligned base: rejected when the check is built in, issued as-is otherwise.
        issue(0, 3'd4, 32'h1002, 32'h10, 3'd2);
        wait_idle(100);

        // Randomized traffic including saturating row counts and stray responses.
        gnt_mode = 1; lat_min = 1; lat_max = 4; spur_en = 1;
        for (int i = 0; i < 25; i++) begin
            issue(1'($urandom), 3'($urandom), $urandom & ~32'h3, $urandom & ~32'h3,
                  3'($urandom_range(7, 0)));
            wait_idle(400);
        end
        spur_en = 0;

        // Asynchronous reset in the middle of ISSUE; late responses must be dropped.
        gnt_mode = 0; lat_min = 20; lat_max = 20;
        issue(0, 3'd7, 32'h5000, 32'h4, 3'd4);
        @(negedge clk);
        #3;
        chk("pre_reset_req", 32'(mem_req_o), 32'd1);
        rst_i = 1;
        #1;
        chk("async_reset_req", 32'(mem_req_o), 32'd0);
        chk("async_reset_busy", 32'(busy_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_i = 0;
        n = 0;
        while (pend.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("late_responses_delivered", 32'(pend.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("idle_after_reset", 32'(busy_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
